// File: rtl/apb2axi_rsp_collector_mt.sv
// ---------------------------------------------------------------------------
// apb2axi_rsp_collector_mt
//
// Collects AXI3 read-data beats and write responses for a multi-tag bridge.
// Every accepted R beat is forwarded through a one-deep output register to a
// read-data FIFO. Per-tag burst state (beat count, sticky error, first
// non-OKAY resp, overrun) is kept while the burst is open. The last beat of a
// read burst and every B response each produce one completion-queue entry.
//
// Ports
//   aclk, aresetn              clock, synchronous active-low reset
//   rid_i .. rvalid_i, rready_o AXI3 R channel
//   bid_i, bresp_i, bvalid_i, bready_o   AXI3 B channel
//   rdf_*                      read-data FIFO push (valid/ready)
//   cq_*                       completion queue push (valid/ready)
//   stat_rd_cpl_o, stat_wr_cpl_o, stat_err_o   wrapping completion counters
// ---------------------------------------------------------------------------
module apb2axi_rsp_collector_mt #(
  parameter int TAG_W  = 4,
  parameter int DATA_W = 64,
  parameter int BEAT_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [TAG_W-1:0]  rid_i,
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [1:0]        rresp_i,
  input  logic              rlast_i,
  input  logic              rvalid_i,
  output logic              rready_o,
  input  logic [TAG_W-1:0]  bid_i,
  input  logic [1:0]        bresp_i,
  input  logic              bvalid_i,
  output logic              bready_o,
  output logic              rdf_vld_o,
  input  logic              rdf_rdy_i,
  output logic [TAG_W-1:0]  rdf_tag_o,
  output logic [DATA_W-1:0] rdf_data_o,
  output logic [1:0]        rdf_resp_o,
  output logic              rdf_last_o,
  output logic              cq_vld_o,
  input  logic              cq_rdy_i,
  output logic              cq_is_write_o,
  output logic [TAG_W-1:0]  cq_tag_o,
  output logic [1:0]        cq_resp_o,
  output logic              cq_error_o,
  output logic [BEAT_W-1:0] cq_num_beats_o,
  output logic              cq_overrun_o,
  output logic [CNT_W-1:0]  stat_rd_cpl_o,
  output logic [CNT_W-1:0]  stat_wr_cpl_o,
  output logic [CNT_W-1:0]  stat_err_o
);

  localparam int TAG_NUM = 2 ** TAG_W;
  localparam logic [BEAT_W-1:0] BEAT_ONE = BEAT_W'(1);
  localparam logic [BEAT_W-1:0] BEAT_MAX = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  logic              rdfVld_q;
  logic [TAG_W-1:0]  rdfTag_q;
  logic [DATA_W-1:0] rdfData_q;
  logic [1:0]        rdfResp_q;
  logic              rdfLast_q;

  logic [TAG_NUM-1:0]             tagInflight_q;
  logic [TAG_NUM-1:0][BEAT_W-1:0] tagCnt_q;
  logic [TAG_NUM-1:0]             tagErr_q;
  logic [TAG_NUM-1:0][1:0]        tagResp_q;
  logic [TAG_NUM-1:0]             tagOvr_q;

  logic              rdPend_q;
  logic [TAG_W-1:0]  rdTag_q;
  logic [1:0]        rdResp_q;
  logic              rdErr_q;
  logic [BEAT_W-1:0] rdBeats_q;
  logic              rdOvr_q;

  logic              wrPend_q;
  logic [TAG_W-1:0]  wrTag_q;
  logic [1:0]        wrResp_q;

  logic              lastGrant_q;

  logic              cqVld_q;
  logic              cqIsWrite_q;
  logic [TAG_W-1:0]  cqTag_q;
  logic [1:0]        cqResp_q;
  logic              cqErr_q;
  logic [BEAT_W-1:0] cqBeats_q;
  logic              cqOvr_q;

  logic [CNT_W-1:0]  statRd_q;
  logic [CNT_W-1:0]  statWr_q;
  logic [CNT_W-1:0]  statErr_q;

  logic              rAcc;
  logic              bAcc;
  logic              rdLoad;
  logic              cqFire;
  logic              cqLoad;
  logic              contested;
  logic              grantWr;
  logic              grantRd;
  logic              respBad;
  logic [BEAT_W-1:0] beatCnt_d;
  logic              beatErr_d;
  logic [1:0]        beatResp_d;
  logic              beatOvr_d;

  // A new R beat is only taken while the read completion slot is empty, so a
  // burst's last beat can never find the slot occupied.
  assign rready_o  = aresetn && (!rdfVld_q || rdf_rdy_i) && !rdPend_q;
  assign bready_o  = aresetn && !wrPend_q;
  assign rAcc      = rvalid_i && rready_o;
  assign bAcc      = bvalid_i && bready_o;
  assign rdLoad    = rAcc && rlast_i;
  assign respBad   = (rresp_i != 2'b00);

  // With both slots pending, last_grant=0 favours the write slot.
  assign cqFire    = cqVld_q && cq_rdy_i;
  assign cqLoad    = (!cqVld_q || cq_rdy_i) && (rdPend_q || wrPend_q);
  assign contested = rdPend_q && wrPend_q;
  assign grantWr   = cqLoad && wrPend_q && (!rdPend_q || !lastGrant_q);
  assign grantRd   = cqLoad && rdPend_q && !grantWr;

  // Burst state after folding in the beat currently on the R channel. The
  // first beat of a tag starts fresh; later beats accumulate, with the count
  // saturating at all-ones and flagging overrun.
  always_comb begin
    beatCnt_d  = BEAT_ONE;
    beatErr_d  = respBad;
    beatResp_d = rresp_i;
    beatOvr_d  = 1'b0;
    if (tagInflight_q[rid_i]) begin
      beatErr_d  = tagErr_q[rid_i] | respBad;
      beatResp_d = (tagResp_q[rid_i] == 2'b00) ? rresp_i : tagResp_q[rid_i];
      if (tagCnt_q[rid_i] == BEAT_MAX) begin
        beatCnt_d = BEAT_MAX;
        beatOvr_d = 1'b1;
      end else begin
        beatCnt_d = tagCnt_q[rid_i] + BEAT_ONE;
        beatOvr_d = tagOvr_q[rid_i];
      end
    end
  end

  // Read-data output register: reloads in the same cycle it drains.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rdfVld_q  <= 1'b0;
      rdfTag_q  <= '0;
      rdfData_q <= '0;
      rdfResp_q <= 2'b00;
      rdfLast_q <= 1'b0;
    end else if (rAcc) begin
      rdfVld_q  <= 1'b1;
      rdfTag_q  <= rid_i;
      rdfData_q <= rdata_i;
      rdfResp_q <= rresp_i;
      rdfLast_q <= rlast_i;
    end else if (rdf_rdy_i) begin
      rdfVld_q  <= 1'b0;
    end
  end

  // Per-tag burst tracking; the last beat hands its totals to the read slot
  // and returns the tag to idle.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      tagInflight_q <= '0;
      tagCnt_q      <= '0;
      tagErr_q      <= '0;
      tagResp_q     <= '0;
      tagOvr_q      <= '0;
    end else if (rAcc) begin
      tagInflight_q[rid_i] <= !rlast_i;
      tagCnt_q[rid_i]      <= rlast_i ? '0 : beatCnt_d;
      tagErr_q[rid_i]      <= rlast_i ? 1'b0 : beatErr_d;
      tagResp_q[rid_i]     <= rlast_i ? 2'b00 : beatResp_d;
      tagOvr_q[rid_i]      <= rlast_i ? 1'b0 : beatOvr_d;
    end
  end

  // Pending completion slots. A load takes priority over the grant so a slot
  // freed and refilled in one cycle stays pending.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rdPend_q    <= 1'b0;
      rdTag_q     <= '0;
      rdResp_q    <= 2'b00;
      rdErr_q     <= 1'b0;
      rdBeats_q   <= '0;
      rdOvr_q     <= 1'b0;
      wrPend_q    <= 1'b0;
      wrTag_q     <= '0;
      wrResp_q    <= 2'b00;
      lastGrant_q <= 1'b0;
    end else begin
      if (rdLoad) begin
        rdPend_q  <= 1'b1;
        rdTag_q   <= rid_i;
        rdResp_q  <= beatResp_d;
        rdErr_q   <= beatErr_d;
        rdBeats_q <= beatCnt_d;
        rdOvr_q   <= beatOvr_d;
      end else if (grantRd) begin
        rdPend_q  <= 1'b0;
      end
      if (bAcc) begin
        wrPend_q  <= 1'b1;
        wrTag_q   <= bid_i;
        wrResp_q  <= bresp_i;
      end else if (grantWr) begin
        wrPend_q  <= 1'b0;
      end
      if (cqLoad && contested) begin
        lastGrant_q <= !lastGrant_q;
      end
    end
  end

  // Completion-queue output register.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      cqVld_q     <= 1'b0;
      cqIsWrite_q <= 1'b0;
      cqTag_q     <= '0;
      cqResp_q    <= 2'b00;
      cqErr_q     <= 1'b0;
      cqBeats_q   <= '0;
      cqOvr_q     <= 1'b0;
    end else if (cqLoad) begin
      cqVld_q <= 1'b1;
      if (grantWr) begin
        cqIsWrite_q <= 1'b1;
        cqTag_q     <= wrTag_q;
        cqResp_q    <= wrResp_q;
        cqErr_q     <= (wrResp_q != 2'b00);
        cqBeats_q   <= '0;
        cqOvr_q     <= 1'b0;
      end else begin
        cqIsWrite_q <= 1'b0;
        cqTag_q     <= rdTag_q;
        cqResp_q    <= rdResp_q;
        cqErr_q     <= rdErr_q;
        cqBeats_q   <= rdBeats_q;
        cqOvr_q     <= rdOvr_q;
      end
    end else if (cqFire) begin
      cqVld_q <= 1'b0;
    end
  end

  // Statistics count completed handshakes and wrap naturally.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      statRd_q  <= '0;
      statWr_q  <= '0;
      statErr_q <= '0;
    end else if (cqFire) begin
      if (cqIsWrite_q) begin
        statWr_q <= statWr_q + CNT_ONE;
      end else begin
        statRd_q <= statRd_q + CNT_ONE;
      end
      if (cqErr_q) begin
        statErr_q <= statErr_q + CNT_ONE;
      end
    end
  end

  assign rdf_vld_o      = rdfVld_q;
  assign rdf_tag_o      = rdfTag_q;
  assign rdf_data_o     = rdfData_q;
  assign rdf_resp_o     = rdfResp_q;
  assign rdf_last_o     = rdfLast_q;
  assign cq_vld_o       = cqVld_q;
  assign cq_is_write_o  = cqIsWrite_q;
  assign cq_tag_o       = cqTag_q;
  assign cq_resp_o      = cqResp_q;
  assign cq_error_o     = cqErr_q;
  assign cq_num_beats_o = cqBeats_q;
  assign cq_overrun_o   = cqOvr_q;
  assign stat_rd_cpl_o  = statRd_q;
  assign stat_wr_cpl_o  = statWr_q;
  assign stat_err_o     = statErr_q;

endmodule
